// File: rtl/beam_pkg.sv
// beam_pkg: FSM state, complex sample type and default parameters shared by beam_search.
package beam_pkg;
  localparam int NUM_MICS_DEF = 4;
  localparam int NUM_BEAMS_DEF = 13;
  localparam int DW_DEF = 14;
  localparam int ANGLE_MIN_DEF = -90;
  localparam int ANGLE_STEP_DEF = 15;
  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, POWER, COMPARE} state_t;
  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;
  function automatic int acc_width(input int dw, input int mics);
    return 2 * dw + $clog2(mics) + 1;
  endfunction
endpackage

// File: rtl/beam_search_if.sv
// beam_search_if: control, result and memory-read signals of beam_search.
// The per-beam power stream exists only when BEAM_SEARCH_PWR_STREAM_EN is defined.
interface beam_search_if import beam_pkg::*; #(
  parameter int NUM_MICS = NUM_MICS_DEF,
  parameter int NUM_BEAMS = NUM_BEAMS_DEF,
  parameter int DW = DW_DEF
) ();
  localparam int SW = $clog2(NUM_MICS);
  localparam int BW = $clog2(NUM_BEAMS);
  localparam int CAW = $clog2(NUM_MICS * NUM_BEAMS);
  localparam int AW = acc_width(DW, NUM_MICS);
  localparam int PW = 2 * AW + 1;
  logic start;
  logic abort;
  logic [9:0] maxbin;
  logic [9:0] spec_rdaddr;
  logic [SW-1:0] spec_sel;
  logic [2*DW-1:0] spec_q;
  logic [CAW-1:0] coef_addr;
  logic [2*DW-1:0] coef_q;
  logic busy;
  logic done;
  logic [BW-1:0] best_beam;
  logic signed [7:0] doa;
  logic [PW-1:0] best_pwr;
`ifdef BEAM_SEARCH_PWR_STREAM_EN
  logic pwr_valid;
  logic [BW-1:0] pwr_beam;
  logic [PW-1:0] pwr;
  modport master (
    output start, abort, maxbin, spec_q, coef_q,
    input spec_rdaddr, spec_sel, coef_addr, busy, done, best_beam, doa, best_pwr,
    input pwr_valid, pwr_beam, pwr
  );
  modport slave (
    input start, abort, maxbin, spec_q, coef_q,
    output spec_rdaddr, spec_sel, coef_addr, busy, done, best_beam, doa, best_pwr,
    output pwr_valid, pwr_beam, pwr
  );
`else
  modport master (
    output start, abort, maxbin, spec_q, coef_q,
    input spec_rdaddr, spec_sel, coef_addr, busy, done, best_beam, doa, best_pwr
  );
  modport slave (
    input start, abort, maxbin, spec_q, coef_q,
    output spec_rdaddr, spec_sel, coef_addr, busy, done, best_beam, doa, best_pwr
  );
`endif
endinterface

// File: rtl/cplx_mult.sv
// cplx_mult: full-precision combinational complex product p = a * b.
module cplx_mult #(
  parameter int DW = 14
) (
  input  logic signed [DW-1:0] a_re_i,
  input  logic signed [DW-1:0] a_im_i,
  input  logic signed [DW-1:0] b_re_i,
  input  logic signed [DW-1:0] b_im_i,
  output logic signed [2*DW:0] p_re_o,
  output logic signed [2*DW:0] p_im_o
);
  localparam int PW2 = 2 * DW;
  logic signed [PW2-1:0] rr, ii, ri, ir;
  assign rr = PW2'(a_re_i) * PW2'(b_re_i);
  assign ii = PW2'(a_im_i) * PW2'(b_im_i);
  assign ri = PW2'(a_re_i) * PW2'(b_im_i);
  assign ir = PW2'(a_im_i) * PW2'(b_re_i);
  assign p_re_o = {rr[PW2-1], rr} - {ii[PW2-1], ii};
  assign p_im_o = {ri[PW2-1], ri} + {ir[PW2-1], ir};
endmodule

// File: rtl/beam_search.sv
// beam_search: finds the steering direction with the highest beamformed power at one FFT bin.
// Define BEAM_SEARCH_PWR_STREAM_EN to expose each beam's power as it is compared.
module beam_search import beam_pkg::*; #(
  parameter int NUM_MICS = NUM_MICS_DEF,
  parameter int NUM_BEAMS = NUM_BEAMS_DEF,
  parameter int DW = DW_DEF,
  parameter int ANGLE_MIN = ANGLE_MIN_DEF,
  parameter int ANGLE_STEP = ANGLE_STEP_DEF
) (
  input logic clk,
  input logic reset,
  beam_search_if.slave bus
);
  localparam int SW = $clog2(NUM_MICS);
  localparam int CW = $clog2(NUM_MICS + 1);
  localparam int BW = $clog2(NUM_BEAMS);
  localparam int CAW = $clog2(NUM_MICS * NUM_BEAMS);
  localparam int AW = acc_width(DW, NUM_MICS);
  localparam int PW = 2 * AW + 1;
  localparam int MW = 2 * DW + 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] mic;
  logic [BW-1:0] beam_q, idx_q, best_beam_q;
  logic [9:0] bin_q;
  logic signed [AW-1:0] acc_re_q, acc_im_q;
  logic [PW-1:0] pwr_q, max_q, best_pwr_q, pwr_c;
  logic signed [7:0] doa_q;
  logic busy_q, done_q, fin_q;
  logic [2*DW-1:0] spec_mem [NUM_MICS];
  logic signed [MW-1:0] p_re, p_im;
  logic signed [2*AW-1:0] sq_re, sq_im;
  logic last_mic, last_beam, kill;
  assign last_mic = cnt_q == CW'(NUM_MICS);
  assign last_beam = beam_q == BW'(NUM_BEAMS - 1);
  assign kill = bus.abort && state_q != IDLE;
  // Read data lags the address by one cycle, so count c consumes mic c-1.
  assign mic = SW'(cnt_q - 1'b1);
  cplx_mult #(.DW(DW)) u_mult (
    .a_re_i(bus.coef_q[2*DW-1:DW]),
    .a_im_i(bus.coef_q[DW-1:0]),
    .b_re_i(spec_mem[mic][2*DW-1:DW]),
    .b_im_i(spec_mem[mic][DW-1:0]),
    .p_re_o(p_re),
    .p_im_o(p_im)
  );
  assign sq_re = (2*AW)'(acc_re_q) * (2*AW)'(acc_re_q);
  assign sq_im = (2*AW)'(acc_im_q) * (2*AW)'(acc_im_q);
  assign pwr_c = {1'b0, sq_re} + {1'b0, sq_im};
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (kill) state_d = IDLE;
    else
      case (state_q)
        IDLE: state_d = (bus.start && !busy_q) ? LOAD : IDLE;
        LOAD: state_d = last_mic ? ACCUM : LOAD;
        ACCUM: state_d = last_mic ? POWER : ACCUM;
        POWER: state_d = COMPARE;
        COMPARE: state_d = last_beam ? IDLE : ACCUM;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (state_q == LOAD && cnt_q != '0) spec_mem[mic] <= bus.spec_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0;
      beam_q <= '0;
      idx_q <= '0;
      bin_q <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      pwr_q <= '0;
      max_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fin_q <= 1'b0;
      best_beam_q <= '0;
      best_pwr_q <= '0;
      doa_q <= '0;
    end else begin
      done_q <= 1'b0;
      fin_q <= 1'b0;
      cnt_q <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
      if (state_q == IDLE && state_d == LOAD) begin
        bin_q <= bus.maxbin;
        busy_q <= 1'b1;
        beam_q <= '0;
        idx_q <= '0;
        max_q <= '0;
      end
      if (state_d == ACCUM && state_q != ACCUM) begin
        acc_re_q <= '0;
        acc_im_q <= '0;
      end else if (state_q == ACCUM && cnt_q != '0) begin
        acc_re_q <= acc_re_q + {{(AW-MW){p_re[MW-1]}}, p_re};
        acc_im_q <= acc_im_q + {{(AW-MW){p_im[MW-1]}}, p_im};
      end
      if (state_q == POWER) pwr_q <= pwr_c;
      if (state_q == COMPARE && !kill) begin
        if (pwr_q > max_q) begin
          max_q <= pwr_q;
          idx_q <= beam_q;
        end
        if (last_beam) fin_q <= 1'b1;
        else beam_q <= beam_q + 1'b1;
      end
      // One cycle after the last compare, publish the winner; busy covers this gap.
      if (fin_q) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
        best_beam_q <= idx_q;
        best_pwr_q <= max_q;
        doa_q <= 8'(ANGLE_MIN + ANGLE_STEP * int'(idx_q));
      end
      if (kill) busy_q <= 1'b0;
    end
  assign bus.spec_rdaddr = bin_q;
  assign bus.spec_sel = (state_q == LOAD && !last_mic) ? SW'(cnt_q) : '0;
  assign bus.coef_addr = (state_q == ACCUM && !last_mic) ? CAW'(int'(beam_q) * NUM_MICS + int'(cnt_q)) : '0;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.best_beam = best_beam_q;
  assign bus.best_pwr = best_pwr_q;
  assign bus.doa = doa_q;
`ifdef BEAM_SEARCH_PWR_STREAM_EN
  assign bus.pwr_valid = state_q == COMPARE;
  assign bus.pwr_beam = beam_q;
  assign bus.pwr = pwr_q;
`endif
endmodule

// File: tb/tb_beam_search.sv
// tb_beam_search: directed checks of beam_search selection, latency, abort, reset and restart rejection.
`timescale 1ns/1ps
module tb_beam_search;
  import beam_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  beam_search_if #(.NUM_MICS(4), .NUM_BEAMS(13), .DW(14)) bus ();
  beam_search_if #(.NUM_MICS(8), .NUM_BEAMS(7), .DW(14)) bus1 ();
  beam_search u0 (.clk(clk), .reset(reset), .bus(bus.slave));
  beam_search #(.NUM_MICS(8), .NUM_BEAMS(7)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  cplx_t spec_tab [4];
  cplx_t coef_tab [64];
  cplx_t coef1_tab [64];
  logic [9:0] bin_ok = 10'd321;
  int n_cmp = 0;
  int n_err = 0;
  always @(posedge clk) begin
    bus.spec_q <= (bus.spec_rdaddr == bin_ok) ? spec_tab[bus.spec_sel] : '0;
    bus.coef_q <= coef_tab[bus.coef_addr];
    bus1.spec_q <= {14'sd1, 14'sd0};
    bus1.coef_q <= coef1_tab[bus1.coef_addr];
  end
`ifdef BEAM_SEARCH_PWR_STREAM_EN
  logic [2:0] pv_beam [$];
  always @(negedge clk) if (bus1.pwr_valid) pv_beam.push_back(bus1.pwr_beam);
`endif
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic cplx_t cx(input int re, input int im);
    cx.re = DW_DEF'(re);
    cx.im = DW_DEF'(im);
  endfunction
  task automatic clear_coef();
    for (int i = 0; i < 64; i++) coef_tab[i] = cx(0, 0);
  endtask
  task automatic set_beam(input int b, input int re, input int im);
    for (int m = 0; m < 4; m++) coef_tab[b*4+m] = cx(re, im);
  endtask
  task automatic set_spec(input int re, input int im);
    for (int m = 0; m < 4; m++) spec_tab[m] = cx(re, im);
  endtask
  // chaos: retry start and move maxbin while busy; neither may disturb the run.
  task automatic run(input bit chaos, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    lat = 0;
    while (!bus.done && lat < 300) begin
      bus.start = chaos && (lat == 1 || lat == 40 || lat == 96);
      bus.maxbin = (chaos && lat >= 1) ? bin_ok + 10'd1 : bin_ok;
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    bus.maxbin = bin_ok;
    check("busy_low_at_done", bus.busy, 0);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
  endtask
  initial begin
    int lat, n;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.maxbin = bin_ok;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus1.maxbin = '0;
    clear_coef();
    set_spec(1000, 0);
    for (int i = 0; i < 64; i++) coef1_tab[i] = cx((i / 8 == 4) ? 2 : 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_beam", bus.best_beam, 0);
    check("rst_doa", bus.doa, 0);
    check("rst_pwr", bus.best_pwr, 0);
    reset = 1'b1;
    set_beam(6, 8191, 0);
    run(1'b0, lat);
    check("t1_latency", lat, 97);
    check("t1_beam", bus.best_beam, 6);
    check("t1_doa", bus.doa, 0);
    check("t1_pwr", bus.best_pwr, 64'd1073479696000000);
    clear_coef();
    set_beam(3, 8191, 0);
    set_beam(9, 8191, 0);
    set_beam(11, 4096, 0);
    run(1'b0, lat);
    check("tie_beam", bus.best_beam, 3);
    check("tie_doa", bus.doa, -45);
    check("tie_pwr", bus.best_pwr, 64'd1073479696000000);
    clear_coef();
    spec_tab[0] = cx(100, 200);
    spec_tab[1] = cx(-300, 0);
    spec_tab[2] = cx(0, 0);
    spec_tab[3] = cx(50, -50);
    coef_tab[3] = cx(1, 0);
    coef_tab[48] = cx(2, 0);
    coef_tab[49] = cx(0, 1);
    coef_tab[50] = cx(7, 7);
    coef_tab[51] = cx(-1, 0);
    run(1'b1, lat);
    check("last_latency", lat, 97);
    check("last_beam", bus.best_beam, 12);
    check("last_doa", bus.doa, 90);
    check("last_pwr", bus.best_pwr, 45000);
    n = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    check("restart_ignored", n, 0);
    set_spec(-8192, -8192);
    clear_coef();
    set_beam(5, -8192, 8191);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (39) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    n = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    check("abort_no_done", n, 0);
    check("abort_keep_beam", bus.best_beam, 12);
    check("abort_keep_pwr", bus.best_pwr, 45000);
    check("abort_keep_doa", bus.doa, 90);
    run(1'b0, lat);
    check("big_latency", lat, 97);
    check("big_beam", bus.best_beam, 5);
    check("big_doa", bus.doa, -15);
    check("big_pwr", bus.best_pwr, (64'sd1 <<< 58) - (64'sd1 <<< 45) + (64'sd1 <<< 31));
    set_spec(1000, 0);
    clear_coef();
    set_beam(6, 8191, 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_beam", bus.best_beam, 0);
    check("mid_rst_doa", bus.doa, 0);
    check("mid_rst_pwr", bus.best_pwr, 0);
    @(negedge clk);
    reset = 1'b1;
    run(1'b0, lat);
    check("post_rst_latency", lat, 97);
    check("post_rst_beam", bus.best_beam, 6);
    check("post_rst_doa", bus.doa, 0);
    clear_coef();
    run(1'b0, lat);
    check("zero_beam", bus.best_beam, 0);
    check("zero_pwr", bus.best_pwr, 0);
    check("zero_doa", bus.doa, -90);
    @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    lat = 0;
    while (!bus1.done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("m8_latency", lat, 87);
    check("m8_beam", bus1.best_beam, 4);
    check("m8_doa", bus1.doa, -30);
    check("m8_pwr", bus1.best_pwr, 256);
`ifdef BEAM_SEARCH_PWR_STREAM_EN
    check("stream_count", pv_beam.size(), 7);
    for (int i = 0; i < 7 && i < pv_beam.size(); i++) check("stream_beam", pv_beam[i], i);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
